// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the wait-stated MEM stage: FSM/size encodings,
// byte-lane strobes, store-data lane placement and load extension.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    function automatic size_e decode_size(input logic word_en, input logic half_en);
        size_e sz;
        if (word_en) begin
            sz = SZ_WORD;
        end else if (half_en) begin
            sz = SZ_HALF;
        end else begin
            sz = SZ_BYTE;
        end
        return sz;
    endfunction

    function automatic logic is_aligned(input size_e sz, input logic [1:0] lo);
        logic ok;
        case (sz)
            SZ_WORD: ok = (lo == 2'b00);
            SZ_HALF: ok = ~lo[0];
            SZ_BYTE: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lane_strobe(input size_e sz, input logic [1:0] lo);
        logic [3:0] stb;
        case (sz)
            SZ_WORD: stb = 4'b1111;
            SZ_HALF: stb = lo[1] ? 4'b1100 : 4'b0011;
            SZ_BYTE: stb = 4'b0001 << lo;
            default: stb = 4'b0000;
        endcase
        return stb;
    endfunction

    // Replicate the low bits of the store data so any strobed lane sees them.
    function automatic logic [31:0] place_data(input size_e sz, input logic [31:0] d);
        logic [31:0] row;
        case (sz)
            SZ_WORD: row = d;
            SZ_HALF: row = {2{d[15:0]}};
            SZ_BYTE: row = {4{d[7:0]}};
            default: row = d;
        endcase
        return row;
    endfunction

    function automatic logic [31:0] extend_row(input logic [31:0] row, input size_e sz,
                                               input logic [1:0] lo, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = row[{lo, 3'b000} +: 8];
        h = lo[1] ? row[31:16] : row[15:0];
        case (sz)
            SZ_BYTE: r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            SZ_WORD: r = row;
            default: r = row;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_stage_ws_dm_bank.sv
// Little-endian data memory of 32-bit rows with per-byte write strobes,
// a registered pipeline read port and a registered debug read port.
module dm_bank #(
    parameter int NB_WADDR = 5
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [NB_WADDR-1:0] i_addr,
    input  logic [3:0]          i_we,
    input  logic [31:0]         i_wdata,
    input  logic                i_re,
    output logic [31:0]         o_rdata,
    input  logic [NB_WADDR-1:0] i_dbg_addr,
    input  logic                i_dbg_re,
    output logic [31:0]         o_dbg_data
);

    logic [3:0][7:0] mem_r [2**NB_WADDR];
    logic [31:0]     rdata_r;
    logic [31:0]     dbg_data_r;

    // Byte-lane writes; contents deliberately survive reset.
    always_ff @(posedge i_clock) begin
        for (int l = 0; l < 4; l++) begin
            if (i_we[l]) begin
                mem_r[i_addr][l] <= i_wdata[8*l +: 8];
            end
        end
    end

    // Registered read ports.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rdata_r    <= 32'd0;
            dbg_data_r <= 32'd0;
        end else begin
            if (i_re) begin
                rdata_r <= mem_r[i_addr];
            end
            if (i_dbg_re) begin
                dbg_data_r <= mem_r[i_dbg_addr];
            end
        end
    end

    assign o_rdata    = rdata_r;
    assign o_dbg_data = dbg_data_r;

endmodule

// File: rtl/mem_stage_ws.sv
// Pipeline MEM stage with a wait-stated data memory, stall handshake,
// sub-word loads/stores, misalignment detection and a debug read port.
module mem_stage_ws
    import mem_stage_pkg::*;
#(
    parameter int NB_DATA     = 32,
    parameter int NB_ADDR     = 32,
    parameter int NB_PC       = 32,
    parameter int NB_REG      = 5,
    parameter int NB_DM_ADDR  = 7,
    parameter int WAIT_STATES = 2,
    parameter int NB_WS       = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_MEM_mem_read,
    input  logic                  i_MEM_mem_write,
    input  logic                  i_MEM_word_en,
    input  logic                  i_MEM_halfword_en,
    input  logic                  i_MEM_byte_en,
    input  logic                  i_MEM_unsigned,
    input  logic [NB_ADDR-1:0]    i_MEM_alu_result,
    input  logic [NB_DATA-1:0]    i_MEM_write_data,
    input  logic                  i_MEM_branch,
    input  logic                  i_MEM_zero,
    input  logic [NB_PC-1:0]      i_MEM_branch_addr,
    input  logic [NB_PC-1:0]      i_MEM_pc,
    input  logic [NB_REG-1:0]     i_MEM_selected_reg,
    input  logic                  i_MEM_reg_write,
    input  logic                  i_MEM_mem_to_reg,
    input  logic                  i_MEM_r31_ctrl,
    input  logic                  i_MEM_hlt,
    input  logic                  i_MEM_dm_read_enable,
    input  logic [NB_DM_ADDR-3:0] i_MEM_dm_read_address,
    output logic                  o_MEM_stall,
    output logic [NB_DATA-1:0]    o_MEM_mem_data,
    output logic                  o_MEM_misaligned,
    output logic                  o_MEM_err_sticky,
    output logic [NB_DATA-1:0]    o_MEM_dbg_data,
    output logic                  o_MEM_dbg_valid,
    output logic                  o_MEM_branch_zero,
    output logic [NB_PC-1:0]      o_MEM_branch_addr,
    output logic [NB_PC-1:0]      o_MEM_pc,
    output logic [NB_ADDR-1:0]    o_MEM_alu_result,
    output logic [NB_REG-1:0]     o_MEM_selected_reg,
    output logic                  o_MEM_reg_write,
    output logic                  o_MEM_mem_to_reg,
    output logic                  o_MEM_r31_ctrl,
    output logic                  o_MEM_hlt
);

    state_e                  state_r, state_next_s;
    logic [NB_WS-1:0]        count_r;
    logic [NB_DM_ADDR-1:0]   addr_r;
    logic [31:0]             wdata_r;
    size_e                   size_r;
    logic                    uns_r, store_r;
    logic [NB_DATA-1:0]      mem_data_r;
    logic                    dbg_valid_r, err_r;

    logic                    request_s, aligned_s, misaligned_s;
    logic                    stall_s, start_s, access_s, dbg_re_s, bank_re_s;
    size_e                   size_s;
    logic [NB_DM_ADDR-3:0]   bank_addr_s;
    logic [3:0]              bank_we_s;
    logic [31:0]             rdata_s, dbg_row_s, load_row_s;

    assign request_s    = i_MEM_mem_read | i_MEM_mem_write;
    assign size_s       = decode_size(i_MEM_word_en, i_MEM_halfword_en);
    assign aligned_s    = is_aligned(size_s, i_MEM_alu_result[1:0]);
    assign misaligned_s = request_s & ~aligned_s;

    // Next-state and handshake decode.
    always_comb begin
        state_next_s = state_r;
        stall_s      = 1'b0;
        start_s      = 1'b0;
        access_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (request_s && aligned_s) begin
                    start_s      = 1'b1;
                    stall_s      = 1'b1;
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                stall_s = 1'b1;
                if (count_r == {NB_WS{1'b0}}) begin
                    access_s     = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // The bank read is launched from the IDLE cycle onward, so the row is
    // already registered by the access edge even with zero wait states.
    assign bank_addr_s = (state_r == ST_IDLE) ? i_MEM_alu_result[NB_DM_ADDR-1:2]
                                              : addr_r[NB_DM_ADDR-1:2];
    assign bank_re_s   = start_s | (state_r == ST_BUSY);
    assign bank_we_s   = (access_s && store_r && !i_reset) ? lane_strobe(size_r, addr_r[1:0]) : 4'b0000;
    assign dbg_re_s    = (state_r == ST_IDLE) & ~request_s & i_MEM_dm_read_enable;
    assign load_row_s  = extend_row(rdata_s, size_r, addr_r[1:0], uns_r);

    dm_bank #(.NB_WADDR(NB_DM_ADDR-2)) u_dm_bank (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_addr     (bank_addr_s),
        .i_we       (bank_we_s),
        .i_wdata    (wdata_r),
        .i_re       (bank_re_s),
        .o_rdata    (rdata_s),
        .i_dbg_addr (i_MEM_dm_read_address),
        .i_dbg_re   (dbg_re_s),
        .o_dbg_data (dbg_row_s)
    );

    // FSM state, wait counter, request capture and registered results.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r     <= ST_IDLE;
            count_r     <= {NB_WS{1'b0}};
            addr_r      <= {NB_DM_ADDR{1'b0}};
            wdata_r     <= 32'd0;
            size_r      <= SZ_BYTE;
            uns_r       <= 1'b0;
            store_r     <= 1'b0;
            mem_data_r  <= {NB_DATA{1'b0}};
            dbg_valid_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            dbg_valid_r <= dbg_re_s;
            err_r       <= err_r | misaligned_s;
            if (start_s) begin
                count_r <= NB_WS'(WAIT_STATES);
                addr_r  <= i_MEM_alu_result[NB_DM_ADDR-1:0];
                wdata_r <= place_data(size_s, i_MEM_write_data[31:0]);
                size_r  <= size_s;
                uns_r   <= i_MEM_unsigned;
                store_r <= i_MEM_mem_write;
            end else if (state_r == ST_BUSY && count_r != {NB_WS{1'b0}}) begin
                count_r <= count_r - NB_WS'(1);
            end
            if (access_s && !store_r) begin
                mem_data_r <= uns_r ? NB_DATA'(load_row_s) : NB_DATA'($signed(load_row_s));
            end else if (state_r == ST_IDLE && misaligned_s) begin
                mem_data_r <= {NB_DATA{1'b0}};
            end
        end
    end

    assign o_MEM_stall        = stall_s;
    assign o_MEM_mem_data     = mem_data_r;
    assign o_MEM_misaligned   = misaligned_s;
    assign o_MEM_err_sticky   = err_r;
    assign o_MEM_dbg_data     = NB_DATA'(dbg_row_s);
    assign o_MEM_dbg_valid    = dbg_valid_r;
    assign o_MEM_branch_zero  = i_MEM_branch & i_MEM_zero & ~stall_s;
    assign o_MEM_branch_addr  = i_MEM_branch_addr;
    assign o_MEM_pc           = i_MEM_pc;
    assign o_MEM_alu_result   = i_MEM_alu_result;
    assign o_MEM_selected_reg = i_MEM_selected_reg;
    assign o_MEM_reg_write    = i_MEM_reg_write;
    assign o_MEM_mem_to_reg   = i_MEM_mem_to_reg;
    assign o_MEM_r31_ctrl     = i_MEM_r31_ctrl;
    assign o_MEM_hlt          = i_MEM_hlt;

endmodule

// File: tb/tb_mem_stage_ws.sv
// Self-checking bench for mem_stage_ws: table of load/store vectors with a
// load-data scoreboard, plus sequences for misalignment, debug, reset and branch.
module tb_mem_stage_ws;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, word_en, half_en, byte_en, uns;
    logic [31:0] alu, wdata, branch_addr, pc;
    logic        branch, zero, reg_write, mem_to_reg, r31_ctrl, hlt;
    logic [4:0]  sel_reg, dbg_addr;
    logic        dbg_en;
    logic        stall, misaligned, err_sticky, dbg_valid, branch_zero;
    logic [31:0] mem_data, dbg_data, o_branch_addr, o_pc, o_alu;
    logic [4:0]  o_sel_reg;
    logic        o_reg_write, o_mem_to_reg, o_r31_ctrl, o_hlt;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        br;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[15];
    logic [31:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    mem_stage_ws #(.WAIT_STATES(WS)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_MEM_mem_read(mem_read), .i_MEM_mem_write(mem_write),
        .i_MEM_word_en(word_en), .i_MEM_halfword_en(half_en), .i_MEM_byte_en(byte_en),
        .i_MEM_unsigned(uns), .i_MEM_alu_result(alu), .i_MEM_write_data(wdata),
        .i_MEM_branch(branch), .i_MEM_zero(zero),
        .i_MEM_branch_addr(branch_addr), .i_MEM_pc(pc), .i_MEM_selected_reg(sel_reg),
        .i_MEM_reg_write(reg_write), .i_MEM_mem_to_reg(mem_to_reg),
        .i_MEM_r31_ctrl(r31_ctrl), .i_MEM_hlt(hlt),
        .i_MEM_dm_read_enable(dbg_en), .i_MEM_dm_read_address(dbg_addr),
        .o_MEM_stall(stall), .o_MEM_mem_data(mem_data), .o_MEM_misaligned(misaligned),
        .o_MEM_err_sticky(err_sticky), .o_MEM_dbg_data(dbg_data), .o_MEM_dbg_valid(dbg_valid),
        .o_MEM_branch_zero(branch_zero), .o_MEM_branch_addr(o_branch_addr), .o_MEM_pc(o_pc),
        .o_MEM_alu_result(o_alu), .o_MEM_selected_reg(o_sel_reg),
        .o_MEM_reg_write(o_reg_write), .o_MEM_mem_to_reg(o_mem_to_reg),
        .o_MEM_r31_ctrl(o_r31_ctrl), .o_MEM_hlt(o_hlt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_req();
        mem_read = 1'b0; mem_write = 1'b0;
        word_en = 1'b0; half_en = 1'b0; byte_en = 1'b0; uns = 1'b0;
        alu = 32'd0; wdata = 32'd0; branch = 1'b0; zero = 1'b0;
    endtask

    // Drive one memory instruction from IDLE and follow it to its DONE cycle.
    task automatic run_op(input vec_t v, input string tag);
        int          n;
        logic [31:0] e;
        mem_read = v.rd; mem_write = v.wr;
        word_en = (v.sz == 2'd2); half_en = (v.sz == 2'd1); byte_en = (v.sz == 2'd0);
        uns = v.uns; alu = v.addr; wdata = v.wdata; branch = v.br; zero = v.br;
        if (v.rd && !v.wr) exp_q.push_back(v.exp);
        n = 0;
        @(negedge clk);
        while (stall === 1'b1 && n < 20) begin
            if (v.br) check({tag, "_bz_stalled"}, 32'(branch_zero), 32'd0);
            if (dbg_en) check({tag, "_dbg_deferred"}, 32'(dbg_valid), 32'd0);
            n++;
            @(negedge clk);
        end
        check({tag, "_stall_cycles"}, 32'(n), 32'(WS + 2));
        if (v.br) check({tag, "_bz_done"}, 32'(branch_zero), 32'd1);
        if (dbg_en) check({tag, "_dbg_done"}, 32'(dbg_valid), 32'd0);
        if (v.rd && !v.wr) begin
            e = exp_q.pop_front();
            check({tag, "_data"}, mem_data, e);
        end
        @(posedge clk);
        #1;
        clear_req();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        vecs[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h09, 32'h12345680, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h09, 32'h0,        1'b0, 32'hFFFFFF80};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h09, 32'h0,        1'b0, 32'h00000080};
        vecs[5]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        1'b0, 32'hDEAD80EF};
        vecs[6]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h0C, 32'h11223344, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h0E, 32'hFFFFA5C3, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0,        1'b0, 32'hA5C33344};
        vecs[9]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h0E, 32'h0,        1'b0, 32'hFFFFA5C3};
        vecs[10] = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h0E, 32'h0,        1'b0, 32'h0000A5C3};
        vecs[11] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h0F, 32'h0,        1'b0, 32'hFFFFFFA5};
        vecs[12] = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h0D, 32'hAAAAAA7F, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0,        1'b0, 32'hA5C37F44};
        vecs[14] = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h0C, 32'h0,        1'b0, 32'h00000044};

        clear_req();
        rst = 1'b1; dbg_en = 1'b0; dbg_addr = 5'd0;
        branch_addr = 32'h0000_0400; pc = 32'h0000_1234; sel_reg = 5'd17;
        reg_write = 1'b1; mem_to_reg = 1'b0; r31_ctrl = 1'b1; hlt = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mem_data", mem_data, 32'd0);
        check("rst_dbg_data", dbg_data, 32'd0);
        check("rst_dbg_valid", 32'(dbg_valid), 32'd0);
        check("rst_err", 32'(err_sticky), 32'd0);
        check("pass_pc", o_pc, 32'h0000_1234);
        check("pass_reg", 32'(o_sel_reg), 32'd17);
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) run_op(vecs[i], $sformatf("v%0d", i));

        // Non-memory instruction: no stall, branch resolves, load data held.
        branch = 1'b1; zero = 1'b1; alu = 32'h0000_0055;
        @(negedge clk);
        check("nomem_stall", 32'(stall), 32'd0);
        check("nomem_bz", 32'(branch_zero), 32'd1);
        check("nomem_hold", mem_data, 32'h00000044);
        check("pass_alu", o_alu, 32'h0000_0055);
        @(posedge clk); #1; clear_req();

        // Debug read while idle.
        dbg_en = 1'b1; dbg_addr = 5'd2;
        @(posedge clk); #1 dbg_en = 1'b0;
        @(negedge clk);
        check("dbg_idle_valid", 32'(dbg_valid), 32'd1);
        check("dbg_idle_data", dbg_data, 32'hDEAD80EF);
        @(negedge clk);
        check("dbg_idle_pulse", 32'(dbg_valid), 32'd0);
        @(posedge clk); #1;

        // Misaligned halfword load.
        mem_read = 1'b1; half_en = 1'b1; alu = 32'h0B;
        @(negedge clk);
        check("mis_flag", 32'(misaligned), 32'd1);
        check("mis_stall", 32'(stall), 32'd0);
        @(posedge clk); #1; clear_req();
        @(negedge clk);
        check("mis_err", 32'(err_sticky), 32'd1);
        check("mis_clear", 32'(misaligned), 32'd0);
        check("mis_data_zero", mem_data, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("mis_err_held", 32'(err_sticky), 32'd1);
        v = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 1'b0, 32'hDEAD80EF};
        run_op(v, "mis_word_intact");

        // Debug read issued while a load is in flight is deferred.
        dbg_en = 1'b1; dbg_addr = 5'd3;
        run_op(v, "dbg_busy_load");
        @(negedge clk);
        check("dbg_busy_idle_wait", 32'(dbg_valid), 32'd0);
        @(posedge clk); #1 dbg_en = 1'b0;
        @(negedge clk);
        check("dbg_busy_valid", 32'(dbg_valid), 32'd1);
        check("dbg_busy_data", dbg_data, 32'hA5C37F44);
        @(posedge clk); #1;

        // Reset on the access edge of a store suppresses the write.
        v = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFEF00D, 1'b0, 32'h0};
        run_op(v, "pre_rst_store");
        mem_write = 1'b1; word_en = 1'b1; alu = 32'h10; wdata = 32'h12345678;
        for (int k = 0; k < WS + 2; k++) begin
            @(negedge clk);
            check($sformatf("rst_op_stall%0d", k), 32'(stall), 32'd1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; clear_req();
        @(negedge clk);
        check("rst_mid_stall", 32'(stall), 32'd0);
        check("rst_mid_err", 32'(err_sticky), 32'd0);
        check("rst_mid_data", mem_data, 32'd0);
        @(posedge clk); #1;
        v = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'hCAFEF00D};
        run_op(v, "rst_store_suppressed");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_ws.md
Name: mem_stage_ws

Overview:
Parametrised successor of the pipeline MEM stage. It adds a multi-cycle data memory with a configurable number of wait states and a stall handshake to the hazard unit. It also adds signed/unsigned sub-word loads, misalignment detection and an arbitrated debug read port. It sits between the EX/MEM and MEM/WB latches and passes all WB and IF control through unchanged, except that the branch decision is gated by the stall.

Parameters:
NB_DATA, 32, data/word width (multiple of 8)
NB_ADDR, 32, ALU result / address width
NB_PC, 32, PC width
NB_REG, 5, register index width
NB_DM_ADDR, 7, byte-address width of data memory (2**NB_DM_ADDR bytes)
WAIT_STATES, 2, extra access cycles (0..15)
NB_WS, 4, wait counter width

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous active-high reset
i_MEM_mem_read  in  1  load request
i_MEM_mem_write  in  1  store request
i_MEM_word_en / i_MEM_halfword_en / i_MEM_byte_en  in  1 each  access size (one-hot)
i_MEM_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend
i_MEM_alu_result  in  NB_ADDR  byte address; low NB_DM_ADDR bits used
i_MEM_write_data  in  NB_DATA  store data
i_MEM_branch, i_MEM_zero  in  1  branch flags
i_MEM_branch_addr, i_MEM_pc  in  NB_PC  pass-through
i_MEM_selected_reg  in  NB_REG  pass-through
i_MEM_reg_write, i_MEM_mem_to_reg, i_MEM_r31_ctrl, i_MEM_hlt  in  1  pass-through
i_MEM_dm_read_enable  in  1  debug read request
i_MEM_dm_read_address  in  NB_DM_ADDR-2  debug word address
o_MEM_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
o_MEM_mem_data  out  NB_DATA  extended load data
o_MEM_misaligned  out  1  current request misaligned (combinational)
o_MEM_err_sticky  out  1  set by any misalignment, cleared only by reset
o_MEM_dbg_data  out  NB_DATA  debug read word
o_MEM_dbg_valid  out  1  one-cycle pulse with o_MEM_dbg_data
o_MEM_branch_zero  out  1  branch & zero & ~o_MEM_stall
o_MEM_branch_addr, o_MEM_pc, o_MEM_alu_result, o_MEM_selected_reg, o_MEM_reg_write, o_MEM_mem_to_reg, o_MEM_r31_ctrl, o_MEM_hlt  out  as inputs  combinational pass-through

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset: IDLE, wait counter 0, o_MEM_mem_data 0, o_MEM_dbg_data 0, o_MEM_dbg_valid 0, o_MEM_err_sticky 0. Memory contents are not cleared.
- Request = mem_read | mem_write. Aligned: byte always; halfword needs addr[0]=0; word needs addr[1:0]=0.
- IDLE + aligned request: capture address, data, size and unsigned flag. Counter <= WAIT_STATES; go to BUSY. o_MEM_stall = 1 combinationally in this cycle.
- BUSY: o_MEM_stall = 1. Counter decrements each cycle. At the edge where counter==0, the access is performed (store writes its byte lanes; load registers the extended data) and the FSM goes to DONE. BUSY therefore lasts WAIT_STATES+1 cycles, and a memory op holds the pipeline for WAIT_STATES+2 stalled cycles plus one DONE cycle.
- DONE: o_MEM_stall = 0 and o_MEM_mem_data is valid. The request inputs, which still belong to the same instruction, are ignored. Go to IDLE unconditionally.
- Non-memory instruction in IDLE: no stall, zero latency; o_MEM_mem_data holds its last value.
- Misaligned request in IDLE: o_MEM_misaligned = 1, o_MEM_err_sticky set, no access, no stall, FSM stays IDLE, o_MEM_mem_data <= 0.
- Memory is little-endian. Byte lane = addr[1:0]; halfword lane = addr[1]. Stores write the low 8/16/32 bits of i_MEM_write_data to the selected lanes only. Loads sign- or zero-extend to NB_DATA according to i_MEM_unsigned.
- Debug read is serviced only in IDLE with no request present: o_MEM_dbg_data is registered the next cycle with an o_MEM_dbg_valid pulse. Otherwise it is deferred while i_MEM_dm_read_enable is held. The pipeline always has priority.
- Reset mid-operation: FSM returns to IDLE. A store whose access edge coincides with reset is suppressed. o_MEM_stall = 0 in the cycle after reset.
- Simultaneous mem_read and mem_write: treated as a store.

Decomposition:
- Package mem_stage_pkg: FSM state encoding, size encoding (BYTE/HALF/WORD), lane-select and extend helper functions.
- Sub-module dm_bank: byte-lane RAM with per-lane write strobes, one registered read port and one registered debug read port.

Test Plan:
- WAIT_STATES=2, sw 0xDEADBEEF @0x08 then lw @0x08 -> each op: stall high 4 cycles, DONE 1 cycle; lw returns 0xDEADBEEF in DONE.
- sb 0x80 @0x09; lb @0x09 -> 0xFFFFFF80; lbu @0x09 -> 0x00000080; lw @0x08 -> 0xDEAD80EF.
- lh @0x0B -> o_MEM_misaligned=1 for that cycle, stall 0, err_sticky=1 and held, word @0x08 unchanged.
- Reset asserted on last BUSY cycle of sw 0x12345678 @0x10 -> word @0x10 keeps prior value; stall 0 next cycle; FSM IDLE.
- Debug read of word 2 while idle -> dbg_valid pulse next cycle with 0xDEAD80EF; issued during BUSY -> served the cycle after DONE→IDLE.
- branch=1, zero=1 arriving with a load -> o_MEM_branch_zero 0 through stalled cycles, 1 in DONE cycle only.
